mem_wb_elastic_reg: RTL and testbench
=====================================

Name: mem_wb_elastic_reg

Overview:
Parametrised MEM/WB pipeline stage, successor to the fixed-width free-running MEM/WB register. Adds valid/ready handshake with a 2-entry skid buffer, synchronous flush, async reset, and r0-write suppression. Sits between data-memory stage and register-file write-back; it stalls cleanly when write-back back-pressures without a combinational ready path.

Parameters:
DATA_W, 32, width of alu_result / read_data / write-back data
REG_ADDR_W, 5, width of destination register index
ZERO_REG_SUPPRESS, 1, when 1 a destination index of 0 forces reg_write low on capture

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
flush  input  1  synchronous squash of all held entries
in_valid  input  1  upstream entry valid
in_ready  output  1  stage can accept (registered, = !skid_valid)
reg_write  input  1  register-file write enable
mem_to_reg  input  1  1 = write-back read_data, 0 = alu_result
alu_result  input  DATA_W  ALU result
read_data  input  DATA_W  memory load data
write_reg  input  REG_ADDR_W  destination register index
out_valid  output  1  main entry valid
out_ready  input  1  write-back consumes entry
reg_write_out  output  1  reg_write of main entry AND out_valid
mem_to_reg_out  output  1  held mem_to_reg
read_data_out  output  DATA_W  held read_data
alu_res_out  output  DATA_W  held alu_result
write_reg_out  output  REG_ADDR_W  held write_reg
wb_data_out  output  DATA_W  mem_to_reg_out ? read_data_out : alu_res_out (combinational from held regs)

Behaviour:
- State: main register (M) + valid bit, skid register (S) + valid bit. Effective states EMPTY (M,S invalid), ONE (M valid), FULL (M,S valid).
- Reset (async, rst=1): both valid bits 0; all held data/control regs 0; in_ready=1; all outputs 0.
- Accept = in_valid & in_ready; consume = out_valid & out_ready.
- EMPTY: accept -> input into M, next ONE. Latency 1 cycle input to output.
- ONE: consume & accept -> input into M, stay ONE; consume only -> EMPTY; accept only -> input into S, next FULL; neither -> hold.
- FULL: in_ready=0; consume -> S moves to M, S invalid, next ONE; else hold. FULL never accepts.
- Entries leave strictly in arrival order; no entry duplicated or dropped except by flush.
- flush=1 (sync): next cycle both valid bits 0, reg_write_out 0; an input presented with flush is discarded; flush has priority over accept/consume. Data regs may retain stale values but reg_write_out must be 0.
- Capture rule: when ZERO_REG_SUPPRESS=1 and write_reg==0, stored reg_write = 0 (other fields stored normally).
- reg_write_out never 1 while out_valid=0.
- in_ready depends only on registered state (no in/out combinational path from out_ready).
- rst asserted mid-transfer: immediate clear as reset; first accept possible on the first rising edge after rst deasserts.

Optional Feature:
MEM_WB_FWD_EN: when defined, adds outputs fwd_valid (1), fwd_reg (REG_ADDR_W), fwd_data (DATA_W) driven from M: fwd_valid = out_valid & reg_write_out & (write_reg_out != 0), fwd_reg = write_reg_out, fwd_data = wb_data_out; used by EX-stage forwarding unit. When undefined, these ports and their logic are absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 mid-run with FULL state -> out_valid=0, in_ready=1, all outputs 0 immediately (before next clk edge).
- Streaming: out_ready=1, in_valid=1 for 4 cycles with alu_result 0x11,0x22,0x33,0x44, mem_to_reg=0 -> wb_data_out shows same sequence one cycle later, in_ready stays 1.
- Back-pressure: out_ready=0 while sending A=0x100, B=0x200 -> after 2 cycles out_valid=1, in_ready=0, out shows A; raise out_ready -> A then B, in_ready returns 1 after A consumed.
- Mux/select: mem_to_reg=1, read_data=0xDEADBEEF, alu_result=0x5 -> wb_data_out=0xDEADBEEF; mem_to_reg=0 -> 0x5.
- Zero reg: reg_write=1, write_reg=0 -> reg_write_out=0 with out_valid=1; write_reg=3 -> reg_write_out=1.
- Flush: FULL state, flush=1 with in_valid=1 -> next cycle out_valid=0, reg_write_out=0, in_ready=1, flushed input never appears; with MEM_WB_FWD_EN, fwd_valid=0.

Source files
------------

// File: rtl/mem_wb_elastic_reg.sv
// MEM/WB pipeline stage with valid/ready handshake and a 2-entry skid buffer.
// Define MEM_WB_FWD_EN to add the EX-stage forwarding outputs (fwd_*).
module mem_wb_elastic_reg #(
  parameter int DATA_W            = 32,
  parameter int REG_ADDR_W        = 5,
  parameter int ZERO_REG_SUPPRESS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     read_data,
  input  logic [REG_ADDR_W-1:0] write_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  reg_write_out,
  output logic                  mem_to_reg_out,
  output logic [DATA_W-1:0]     read_data_out,
  output logic [DATA_W-1:0]     alu_res_out,
  output logic [REG_ADDR_W-1:0] write_reg_out,
  output logic [DATA_W-1:0]     wb_data_out
`ifdef MEM_WB_FWD_EN
  ,
  output logic                  fwd_valid,
  output logic [REG_ADDR_W-1:0] fwd_reg,
  output logic [DATA_W-1:0]     fwd_data
`endif
);

  typedef struct packed {
    logic                  rw;
    logic                  m2r;
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     rd;
    logic [REG_ADDR_W-1:0] wr;
  } ent_t;

  ent_t m_q, m_d, s_q, s_d, in_e;
  logic mv_q, mv_d, sv_q, sv_d;
  logic accept, consume;

  // Writes to r0 are dropped at capture so they never reach the register file.
  always_comb begin
    in_e.rw  = reg_write;
    in_e.m2r = mem_to_reg;
    in_e.alu = alu_result;
    in_e.rd  = read_data;
    in_e.wr  = write_reg;
    if (ZERO_REG_SUPPRESS != 0 && write_reg == '0)
      in_e.rw = 1'b0;
  end

  assign in_ready = !sv_q;
  assign out_valid = mv_q;
  assign accept = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_comb begin
    m_d  = m_q;
    s_d  = s_q;
    mv_d = mv_q;
    sv_d = sv_q;
    if (flush) begin
      mv_d = 1'b0;
      sv_d = 1'b0;
    end else if (!mv_q) begin
      if (accept) begin
        m_d  = in_e;
        mv_d = 1'b1;
      end
    end else if (!sv_q) begin
      if (consume) begin
        if (accept) m_d = in_e;
        else mv_d = 1'b0;
      end else if (accept) begin
        s_d  = in_e;
        sv_d = 1'b1;
      end
    end else if (consume) begin
      m_d  = s_q;
      sv_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q  <= '0;
      s_q  <= '0;
      mv_q <= 1'b0;
      sv_q <= 1'b0;
    end else begin
      m_q  <= m_d;
      s_q  <= s_d;
      mv_q <= mv_d;
      sv_q <= sv_d;
    end
  end

  assign reg_write_out  = m_q.rw & mv_q;
  assign mem_to_reg_out = m_q.m2r;
  assign read_data_out  = m_q.rd;
  assign alu_res_out    = m_q.alu;
  assign write_reg_out  = m_q.wr;
  assign wb_data_out    = m_q.m2r ? m_q.rd : m_q.alu;

`ifdef MEM_WB_FWD_EN
  assign fwd_valid = mv_q & reg_write_out & (m_q.wr != '0);
  assign fwd_reg   = m_q.wr;
  assign fwd_data  = wb_data_out;
`endif

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Directed vector bench for mem_wb_elastic_reg.
// Rows: inputs before an edge, expected outputs just after it.
module tb_mem_wb_elastic_reg;

  logic        clk, rst, flush, in_valid, in_ready;
  logic        reg_write, mem_to_reg, out_valid, out_ready;
  logic        reg_write_out, mem_to_reg_out;
  logic [31:0] alu_result, read_data, read_data_out;
  logic [31:0] alu_res_out, wb_data_out;
  logic [4:0]  write_reg, write_reg_out;
`ifdef MEM_WB_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_reg;
  logic [31:0] fwd_data;
`endif

  int total = 0;
  int passed = 0;

  mem_wb_elastic_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .alu_result(alu_result), .read_data(read_data),
    .write_reg(write_reg),
    .out_valid(out_valid), .out_ready(out_ready),
    .reg_write_out(reg_write_out),
    .mem_to_reg_out(mem_to_reg_out),
    .read_data_out(read_data_out),
    .alu_res_out(alu_res_out),
    .write_reg_out(write_reg_out),
    .wb_data_out(wb_data_out)
`ifdef MEM_WB_FWD_EN
    ,
    .fwd_valid(fwd_valid), .fwd_reg(fwd_reg),
    .fwd_data(fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv, ordy, fl, rw, m2r;
    logic [31:0] alu, rd;
    logic [4:0]  wr;
    logic        ov, ir, rwo, chk_wb;
    logic [31:0] wb;
  } vec_t;

  vec_t v[18];

  function automatic vec_t mk(
    logic iv, logic ordy, logic fl, logic rw, logic m2r,
    logic [31:0] alu, logic [31:0] rd, logic [4:0] wr,
    logic ov, logic ir, logic rwo, logic chk_wb,
    logic [31:0] wb);
    vec_t r;
    r.iv = iv; r.ordy = ordy; r.fl = fl; r.rw = rw;
    r.m2r = m2r; r.alu = alu; r.rd = rd; r.wr = wr;
    r.ov = ov; r.ir = ir; r.rwo = rwo;
    r.chk_wb = chk_wb; r.wb = wb;
    return r;
  endfunction

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  task automatic drive(vec_t r);
    in_valid = r.iv; out_ready = r.ordy; flush = r.fl;
    reg_write = r.rw; mem_to_reg = r.m2r;
    alu_result = r.alu; read_data = r.rd; write_reg = r.wr;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; reg_write = 1'b0; mem_to_reg = 1'b0;
    alu_result = '0; read_data = '0; write_reg = '0;

    //      iv ordy fl rw m2r alu       rd          wr  ov ir rwo chk wb
    v[0]  = mk(1, 1, 0, 1, 0, 32'h11,  32'h0,       1, 1, 1, 1, 1, 32'h11);
    v[1]  = mk(1, 1, 0, 1, 0, 32'h22,  32'h0,       1, 1, 1, 1, 1, 32'h22);
    v[2]  = mk(1, 1, 0, 1, 0, 32'h33,  32'h0,       1, 1, 1, 1, 1, 32'h33);
    v[3]  = mk(1, 1, 0, 1, 0, 32'h44,  32'h0,       1, 1, 1, 1, 1, 32'h44);
    v[4]  = mk(0, 1, 0, 0, 0, 32'h0,   32'h0,       0, 0, 1, 0, 0, 32'h0);
    v[5]  = mk(1, 0, 0, 1, 0, 32'h100, 32'h0,       2, 1, 1, 1, 1, 32'h100);
    v[6]  = mk(1, 0, 0, 1, 0, 32'h200, 32'h0,       2, 1, 0, 1, 1, 32'h100);
    v[7]  = mk(1, 0, 0, 1, 0, 32'h300, 32'h0,       2, 1, 0, 1, 1, 32'h100);
    v[8]  = mk(0, 1, 0, 0, 0, 32'h0,   32'h0,       0, 1, 1, 1, 1, 32'h200);
    v[9]  = mk(0, 1, 0, 0, 0, 32'h0,   32'h0,       0, 0, 1, 0, 0, 32'h0);
    v[10] = mk(1, 0, 0, 1, 1, 32'h5,   32'hDEADBEEF, 3, 1, 1, 1, 1, 32'hDEADBEEF);
    v[11] = mk(1, 1, 0, 1, 0, 32'h5,   32'hDEADBEEF, 3, 1, 1, 1, 1, 32'h5);
    v[12] = mk(1, 1, 0, 1, 0, 32'h77,  32'h0,       0, 1, 1, 0, 1, 32'h77);
    v[13] = mk(1, 1, 0, 1, 0, 32'h78,  32'h0,       3, 1, 1, 1, 1, 32'h78);
    v[14] = mk(1, 0, 0, 1, 0, 32'hA1,  32'h0,       4, 1, 0, 1, 1, 32'h78);
    v[15] = mk(1, 1, 1, 1, 0, 32'hBAD, 32'h0,       6, 0, 1, 0, 0, 32'h0);
    v[16] = mk(0, 1, 0, 0, 0, 32'h0,   32'h0,       0, 0, 1, 0, 0, 32'h0);
    v[17] = mk(1, 1, 0, 1, 0, 32'h55,  32'h0,       5, 1, 1, 1, 1, 32'h55);

    #2;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_wb_data", wb_data_out, 32'h0);
    chk("rst_reg_write_out", {31'b0, reg_write_out}, 32'd0);
    #10 rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(v[i]);
      @(posedge clk);
      #1;
      chk($sformatf("row%0d_out_valid", i),
          {31'b0, out_valid}, {31'b0, v[i].ov});
      chk($sformatf("row%0d_in_ready", i),
          {31'b0, in_ready}, {31'b0, v[i].ir});
      chk($sformatf("row%0d_reg_write_out", i),
          {31'b0, reg_write_out}, {31'b0, v[i].rwo});
      if (v[i].chk_wb)
        chk($sformatf("row%0d_wb_data", i),
            wb_data_out, v[i].wb);
`ifdef MEM_WB_FWD_EN
      chk($sformatf("row%0d_fwd_valid", i),
          {31'b0, fwd_valid}, {31'b0, v[i].rwo});
`endif
    end

    // Fill to FULL, then reset asynchronously mid-cycle.
    drive(mk(1, 0, 0, 1, 1, 32'h66, 32'h6666, 7,
             0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    chk("pre_rst_full_in_ready", {31'b0, in_ready}, 32'd0);
    #1 rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("async_rst_wb_data", wb_data_out, 32'h0);
    chk("async_rst_reg_write_out",
        {31'b0, reg_write_out}, 32'd0);
    chk("async_rst_write_reg_out",
        {27'b0, write_reg_out}, 32'd0);
    chk("async_rst_m2r_out", {31'b0, mem_to_reg_out}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    drive(mk(1, 0, 0, 1, 0, 32'h99, 32'h0, 9,
             0, 0, 0, 0, 32'h0));
    @(posedge clk);
    #1;
    chk("post_rst_accept_valid", {31'b0, out_valid}, 32'd1);
    chk("post_rst_accept_wb", wb_data_out, 32'h99);
    chk("post_rst_write_reg", {27'b0, write_reg_out}, 32'd9);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
